// File: rtl/ip_instr_queue.sv
// Two-wide in-order decoded-instruction queue between the decoder and the issuer.
// Circular buffer with pair writes at tail and pair reads at head; flush clears the pointers.
module ip_instr_queue #(
  parameter int DEPTH  = 8,
  parameter int INFO_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [1:0]        in_valid,
  input  logic [INFO_W-1:0] in_info [2],
  output logic              decoder_stop,
  output logic [1:0]        out_valid,
  output logic [INFO_W-1:0] out_info [2],
  input  logic              issuer_stop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] STOP_LIM = CW'(DEPTH - 2);

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [INFO_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              wr0_en, wr1_en;
  logic [PW-1:0]     wr0_addr, wr1_addr;
  logic [1:0]        push_n, pop_n;

  // Stop depends on stored occupancy only, so there is no path from issuer or decoder.
  assign decoder_stop = (count_q > STOP_LIM);
  assign out_valid[0] = (count_q != '0);
  assign out_valid[1] = (count_q > CW'(1));
  assign out_info[0]  = mem_q[head_q];
  assign out_info[1]  = mem_q[head_q + PW'(1)];

  always_comb begin
    accept   = !decoder_stop && !flush;
    wr0_en   = accept && in_valid[0];
    wr1_en   = accept && in_valid[1];
    wr0_addr = tail_q;
    // A lone slot-1 push lands at tail so no hole is left in the buffer.
    wr1_addr = in_valid[0] ? tail_q + PW'(1) : tail_q;
    push_n   = {1'b0, wr0_en} + {1'b0, wr1_en};
    pop_n    = 2'd0;
    if (!issuer_stop && !flush) begin
      pop_n = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
    end

    head_d  = head_q + PW'(pop_n);
    tail_d  = tail_q + PW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately not reset; validity comes from count alone.
  always_ff @(posedge clock) begin
    if (wr0_en) mem_q[wr0_addr] <= in_info[0];
    if (wr1_en) mem_q[wr1_addr] <= in_info[1];
  end

endmodule

// File: doc/ip_instr_queue.md
# ip_instr_queue

Two-wide in-order decoded-instruction queue between the decoder and `ip_issuer`. It accepts up to two decoded instructions per cycle and presents the oldest two to the issuer. It absorbs issuer stalls caused by reservation-station or ROB fullness, so the decoder only stops when the queue itself runs out of space. A flush input discards all queued instructions on branch mispredict or exception.

## Interface
- `DEPTH`, 8: queue entries, one instruction each; power of two, ≥ 4.
- `INFO_W`, 128: width of one packed instruction-info record (address, immediate, instr_name, instr_type, regs, flags, packed in that order, MSB first).

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all entries.
- `in_valid[2]`  in  1 each  decoder slot valid; slot 0 is older.
- `in_info[2]`  in  INFO_W each  decoder slot payload.
- `decoder_stop`  out  1  queue cannot accept a 2-wide push this cycle.
- `out_valid[2]`  out  1 each  issuer slot valid; slot 0 is oldest.
- `out_info[2]`  out  INFO_W each  issuer slot payload.
- `issuer_stop`  in  1  issuer not consuming this cycle.

## Operation
- Storage: circular buffer of DEPTH × INFO_W. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Push count: `push_n` is 0 when `decoder_stop` or `flush` is high. Otherwise it is `in_valid[0] + in_valid[1]`.
  - `in_valid[1]` with `in_valid[0]` low is illegal and the bench asserts on it. The design then pushes slot 1 alone.
  - Slot 0 is written at `tail` and slot 1 at `tail+1`. Tail advances by `push_n`.
- `decoder_stop = (DEPTH - count) < 2`. It depends on the current `count` only. It never depends on same-cycle pop, `issuer_stop` or `in_valid`, so there is no combinational path from the issuer or decoder.
- Outputs are read combinationally from storage:
  - `out_info[0]` = entry at `head`; `out_info[1]` = entry at `head+1`.
  - `out_valid[0] = count ≥ 1`; `out_valid[1] = count ≥ 2`.
- Pop count: `pop_n` is 0 when `issuer_stop` or `flush` is high. Otherwise it is `out_valid[0] + out_valid[1]`. The issuer latches both slots together, so a partial pop of slot 0 only never occurs. Head advances by `pop_n`.
- Count update: `count_next = count + push_n - pop_n`. Overflow is impossible because `decoder_stop` guarantees at least 2 free entries. Underflow is impossible because `pop_n ≤ count`.
- Flush: head, tail and count are cleared to 0 at the next edge. Same-cycle push and pop are discarded. Storage contents are not cleared.
- Invalid outputs: `out_info` of an invalid slot is don't-care. Its payload must not be X-checked.

## Timing
- Reset, asynchronous on `reset` low: head = tail = count = 0. This gives `out_valid` = 0, 0 and `decoder_stop` = 0. Storage is not reset. Release is synchronous to `clock`.
- Latency: an instruction pushed at edge N appears on `out_valid/out_info` after edge N, so it can be consumed by the issuer at edge N+1. Minimum fall-through is 1 cycle.
- Throughput: 2 instructions per cycle in and out at steady state.
- Simultaneous push and pop in one cycle are both applied. A full-rate stream therefore holds `count` constant.
- Wrap-around: the pair write or read at `tail/head = DEPTH-1` uses entry DEPTH-1 for slot 0 and entry 0 for slot 1.
- Boundary values:
  - `count = DEPTH-1` or `DEPTH`: `decoder_stop` = 1.
  - `count = DEPTH-2`: `decoder_stop` = 0.
  - `count = 1`: only slot 0 is valid, and a pop consumes one entry.
- Flush concurrent with reset: reset dominates.
- Flush while `decoder_stop` = 1: `decoder_stop` = 0 on the next cycle.

## Test plan
- **Reset mid-stream:** fill 5 entries, pulse `reset` low between edges -> outputs go immediately to `out_valid` = 0, 0 and `decoder_stop` = 0; the first push after release appears at slot 0.
- **Fill to full:** `issuer_stop` = 1, push pairs A0/A1, A2/A3, A4/A5 -> `count` = 6 and `decoder_stop` = 0. Push A6/A7 -> `count` = 8 and `decoder_stop` = 1. Hold a further push of A8/A9 -> it is ignored and `count` stays 8.
- **Drain in order:** from the full state, release `issuer_stop` -> out pairs A0/A1, A2/A3, A4/A5, A6/A7 on consecutive cycles, then `out_valid` = 0, 0.
- **Odd count and wrap:** push singles until head = 7. Issue a pair that spans entries 7 and 0 -> `out_info[0]`/`out_info[1]` equal the pushed order. A single leftover entry gives `out_valid` = 1, 0 and pops as one.
- **Simultaneous push/pop at rate:** `count` = 4, then 20 cycles of 2-in/2-out -> `count` stays 4, `decoder_stop` stays 0, and output order equals input order.
- **Flush:** `count` = 7 with push and pop active on the flush cycle -> the next cycle shows `count` = 0, `out_valid` = 0, 0 and `decoder_stop` = 0, and the first post-flush push B0 appears at slot 0.
